// File: rtl/ex_core_pkg.sv
// ex_core_pkg: shared types and constants for the ex_core datapath
package ex_core_pkg;
  localparam int SUM_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} t_sum_acc_state;
endpackage

// File: rtl/ex_core_sum_acc.sv
// ex_core_sum_acc: reduces a programmed number of 4-bit adder sums into one wide total
module ex_core_sum_acc
  import ex_core_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Start,
  input  logic [CNT_W-1:0] NumSamples,
  input  logic             SumValid,
  input  logic [SUM_W-1:0] SumData,
  output logic             SumReady,
  output logic             AccValid,
  output logic [ACC_W-1:0] AccData,
  output logic             AccOvf,
  input  logic             AccReady,
  output logic             Busy
);
  t_sum_acc_state   state;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W:0]   sum_ext;
  // the extra top bit is the carry out of the accumulator
  assign sum_ext  = {1'b0, AccData} + {{(ACC_W+1-SUM_W){1'b0}}, SumData};
  assign SumReady = state == S_ACC;
  assign AccValid = state == S_DONE;
  assign Busy     = state != S_IDLE;
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state     <= S_IDLE;
      AccData   <= '0;
      AccOvf    <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          AccData   <= '0;
          AccOvf    <= 1'b0;
          remaining <= NumSamples;
          state     <= NumSamples == '0 ? S_DONE : S_ACC;
        end
        S_ACC: if (SumValid) begin
          AccData   <= sum_ext[ACC_W-1:0];
          AccOvf    <= AccOvf | sum_ext[ACC_W];
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE: if (AccReady) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
